// File: rtl/reg_write_sched_pkg.sv
// Shared types and sizing for the register-file write scheduler.
package reg_write_sched_pkg;

    localparam int kDefW    = 8;
    localparam int kDefD    = 4;
    localparam int kNumRegs = 2**kDefD;

    typedef enum logic {ST_CLEAR, ST_RUN} sched_st_t;

endpackage

// File: rtl/reg_write_sched.sv
// Arbitrates the register-file write port between ALU and load-return writeback,
// clears the file after reset and scoreboards a single outstanding load.
module reg_write_sched
    import reg_write_sched_pkg::*;
#(
    parameter int W = kDefW,
    parameter int D = kDefD
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic         alu_req,
    input  logic [D-1:0] alu_addr,
    input  logic [W-1:0] alu_data,
    output logic         alu_gnt,
    input  logic         ld_issue,
    input  logic [D-1:0] ld_dest,
    output logic         ld_ready,
    input  logic         ld_valid,
    input  logic [W-1:0] ld_data,
    input  logic [D-1:0] rd_addr,
    output logic         stall,
    output logic         wr_en,
    output logic [D-1:0] wr_addr,
    output logic [W-1:0] wr_data,
    output logic         init_done,
    output logic         err
);

    sched_st_t    state;
    logic [D-1:0] clr_cnt;
    logic         pend;
    logic [D-1:0] pend_dest;

    logic ld_ret;
    logic waw_block;

    assign ld_ret    = ld_valid && pend;
    assign waw_block = pend && (alu_addr == pend_dest);

    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        alu_gnt = 1'b0;
        if (!Reset) begin
            case (state)
                ST_CLEAR: begin
                    wr_en   = 1'b1;
                    wr_addr = clr_cnt;
                end
                ST_RUN: begin
                    if (ld_ret) begin
                        wr_en   = 1'b1;
                        wr_addr = pend_dest;
                        wr_data = ld_data;
                    end else if (alu_req && !waw_block) begin
                        wr_en   = 1'b1;
                        alu_gnt = 1'b1;
                        wr_addr = alu_addr;
                        wr_data = alu_data;
                    end
                end
                default: ;
            endcase
        end
    end

    // A returning load frees the slot in the same cycle, so a new load may issue behind it.
    assign ld_ready = !Reset && (state == ST_RUN) && (!pend || ld_valid);

    // Returning data is forwarded by the decoder, hence no stall in the return cycle.
    assign stall = Reset || !init_done || (pend && (rd_addr == pend_dest) && !ld_valid);

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state     <= ST_CLEAR;
            clr_cnt   <= '0;
            pend      <= 1'b0;
            pend_dest <= '0;
            init_done <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + D'(1);
                    if (clr_cnt == '1) begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (ld_valid && !pend)
                        err <= 1'b1;
                    if (ld_issue && ld_ready) begin
                        pend      <= 1'b1;
                        pend_dest <= ld_dest;
                    end else if (ld_ret) begin
                        pend <= 1'b0;
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_write_sched.sv
// Directed self-checking bench for reg_write_sched with hand-computed expectations.
module tb_reg_write_sched;
    import reg_write_sched_pkg::*;

    localparam int W = kDefW;
    localparam int D = kDefD;

    logic         CLK = 1'b0;
    logic         Reset;
    logic         alu_req;
    logic [D-1:0] alu_addr;
    logic [W-1:0] alu_data;
    logic         alu_gnt;
    logic         ld_issue;
    logic [D-1:0] ld_dest;
    logic         ld_ready;
    logic         ld_valid;
    logic [W-1:0] ld_data;
    logic [D-1:0] rd_addr;
    logic         stall;
    logic         wr_en;
    logic [D-1:0] wr_addr;
    logic [W-1:0] wr_data;
    logic         init_done;
    logic         err;

    int checks = 0;
    int errors = 0;

    reg_write_sched #(.W(W), .D(D)) dut (
        .CLK(CLK), .Reset(Reset),
        .alu_req(alu_req), .alu_addr(alu_addr), .alu_data(alu_data), .alu_gnt(alu_gnt),
        .ld_issue(ld_issue), .ld_dest(ld_dest), .ld_ready(ld_ready),
        .ld_valid(ld_valid), .ld_data(ld_data),
        .rd_addr(rd_addr), .stall(stall),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .init_done(init_done), .err(err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1-2 ns after the edge.
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_write(input string tag, input logic en, input logic [D-1:0] a,
                               input logic [W-1:0] d, input logic gnt);
        check({tag, ".wr_en"}, 32'(wr_en), 32'(en));
        if (en) begin
            check({tag, ".wr_addr"}, 32'(wr_addr), 32'(a));
            check({tag, ".wr_data"}, 32'(wr_data), 32'(d));
        end
        check({tag, ".alu_gnt"}, 32'(alu_gnt), 32'(gnt));
    endtask

    // Runs the full clear sequence starting right after Reset drops, with optional noise inputs.
    task automatic clear_seq(input logic noise, input int abort_at);
        for (int i = 0; i < kNumRegs; i++) begin
            alu_req  = noise;
            alu_addr = 4'd7;
            alu_data = 8'hEE;
            ld_valid = noise;
            ld_issue = noise;
            ld_dest  = 4'd2;
            settle();
            check_write($sformatf("clr%0d", i), 1'b1, D'(i), '0, 1'b0);
            check("clr.stall", 32'(stall), 32'd1);
            check("clr.ld_ready", 32'(ld_ready), 32'd0);
            check("clr.init_done", 32'(init_done), 32'd0);
            if (i == abort_at) return;
            cyc();
        end
        alu_req  = 1'b0;
        ld_valid = 1'b0;
        ld_issue = 1'b0;
        settle();
        check("clr.done", 32'(init_done), 32'd1);
        check("clr.err", 32'(err), 32'd0);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; alu_req = 1'b1; alu_addr = 4'd1; alu_data = 8'h99;
        ld_issue = 1'b1; ld_dest = 4'd1; ld_valid = 1'b1; ld_data = 8'h00; rd_addr = 4'd0;
        cyc();
        settle();
        check_write("rst", 1'b0, '0, '0, 1'b0);
        check("rst.stall", 32'(stall), 32'd1);
        check("rst.ld_ready", 32'(ld_ready), 32'd0);
        cyc();
        Reset = 1'b0;
        clear_seq(1'b0, -1);
        check("run.stall", 32'(stall), 32'd0);
        check("run.ld_ready", 32'(ld_ready), 32'd1);

        // Reset at clear cycle 7 restarts the count from zero.
        do_reset();
        clear_seq(1'b1, 7);
        Reset = 1'b1;
        settle();
        check_write("midrst", 1'b0, '0, '0, 1'b0);
        cyc();
        Reset = 1'b0;
        clear_seq(1'b1, -1);

        // WAW: ALU write to the pending load destination waits for the load to retire.
        ld_issue = 1'b1; ld_dest = 4'd5;
        settle();
        check("waw.ld_ready", 32'(ld_ready), 32'd1);
        cyc();
        ld_issue = 1'b0;
        alu_req = 1'b1; alu_addr = 4'd5; alu_data = 8'h3C;
        for (int i = 0; i < 2; i++) begin
            settle();
            check_write("waw.blk", 1'b0, '0, '0, 1'b0);
            check("waw.ld_ready", 32'(ld_ready), 32'd0);
            cyc();
        end
        ld_valid = 1'b1; ld_data = 8'hA1;
        settle();
        check_write("waw.ret", 1'b1, 4'd5, 8'hA1, 1'b0);
        cyc();
        ld_valid = 1'b0;
        settle();
        check_write("waw.alu", 1'b1, 4'd5, 8'h3C, 1'b1);
        cyc();
        alu_req = 1'b0;
        settle();
        check_write("waw.idle", 1'b0, '0, '0, 1'b0);

        // Load return beats a non-conflicting ALU write.
        ld_issue = 1'b1; ld_dest = 4'd5;
        cyc();
        ld_issue = 1'b0;
        ld_valid = 1'b1; ld_data = 8'h11;
        alu_req = 1'b1; alu_addr = 4'd2; alu_data = 8'h22;
        settle();
        check_write("pri.ld", 1'b1, 4'd5, 8'h11, 1'b0);
        cyc();
        ld_valid = 1'b0;
        settle();
        check_write("pri.alu", 1'b1, 4'd2, 8'h22, 1'b1);
        cyc();
        alu_req = 1'b0;

        // RAW stall, ignored issue while busy, back-to-back issue in the return cycle.
        ld_issue = 1'b1; ld_dest = 4'd3;
        cyc();
        ld_dest = 4'd12;
        rd_addr = 4'd3;
        settle();
        check("raw.stall", 32'(stall), 32'd1);
        check("raw.ld_ready", 32'(ld_ready), 32'd0);
        rd_addr = 4'd4;
        settle();
        check("raw.other", 32'(stall), 32'd0);
        cyc();
        ld_issue = 1'b0;
        rd_addr = 4'd3;
        settle();
        check("raw.hold", 32'(stall), 32'd1);
        ld_valid = 1'b1; ld_data = 8'h77; ld_issue = 1'b1; ld_dest = 4'd9;
        settle();
        check("raw.retstall", 32'(stall), 32'd0);
        check("raw.b2b_ready", 32'(ld_ready), 32'd1);
        check_write("raw.ret", 1'b1, 4'd3, 8'h77, 1'b0);
        cyc();
        ld_valid = 1'b0; ld_issue = 1'b0;
        settle();
        check("raw.r3free", 32'(stall), 32'd0);
        rd_addr = 4'd12;
        settle();
        check("raw.r12", 32'(stall), 32'd0);
        rd_addr = 4'd9;
        alu_req = 1'b1; alu_addr = 4'd9; alu_data = 8'h44;
        settle();
        check("raw.r9", 32'(stall), 32'd1);
        check_write("raw.waw9", 1'b0, '0, '0, 1'b0);
        alu_req = 1'b0;
        ld_valid = 1'b1; ld_data = 8'h55;
        settle();
        check_write("raw.ret9", 1'b1, 4'd9, 8'h55, 1'b0);
        cyc();
        ld_valid = 1'b0;
        settle();
        check("raw.r9free", 32'(stall), 32'd0);

        // Spurious return sets sticky err; a Reset clears it and drops a pending load.
        ld_valid = 1'b1; ld_data = 8'hFF;
        settle();
        check_write("err.nowr", 1'b0, '0, '0, 1'b0);
        check("err.before", 32'(err), 32'd0);
        cyc();
        ld_valid = 1'b0;
        ld_issue = 1'b1; ld_dest = 4'd6;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("err.sticky", 32'(err), 32'd1);
            cyc();
            ld_issue = 1'b0;
        end
        do_reset();
        settle();
        check("err.cleared", 32'(err), 32'd0);
        clear_seq(1'b0, -1);
        rd_addr = 4'd6;
        settle();
        check("rst.droppend", 32'(stall), 32'd0);
        check("rst.ready", 32'(ld_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
